// File: rtl/wb_arbiter_if.sv
// Bus bundle for wb_arbiter: two producer handshakes, the GPR write port and busy.
// WB_BYPASS_EN adds the forwarding lookup signals.
interface wb_arbiter_if;
  logic        alu_valid;
  logic [2:0]  alu_dest;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [2:0]  mem_dest;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic        reg_write_en;
  logic [2:0]  reg_write_dest;
  logic [15:0] reg_write_data;
  logic        busy;
`ifdef WB_BYPASS_EN
  logic [2:0]  byp_addr_1;
  logic [2:0]  byp_addr_2;
  logic        byp_hit_1;
  logic        byp_hit_2;
  logic [15:0] byp_data_1;
  logic [15:0] byp_data_2;

  modport master (
    output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
    output byp_addr_1, byp_addr_2,
    input  alu_ready, mem_ready, reg_write_en, reg_write_dest, reg_write_data, busy,
    input  byp_hit_1, byp_hit_2, byp_data_1, byp_data_2
  );
  modport slave (
    input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
    input  byp_addr_1, byp_addr_2,
    output alu_ready, mem_ready, reg_write_en, reg_write_dest, reg_write_data, busy,
    output byp_hit_1, byp_hit_2, byp_data_1, byp_data_2
  );
`else
  modport master (
    output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
    input  alu_ready, mem_ready, reg_write_en, reg_write_dest, reg_write_data, busy
  );
  modport slave (
    input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
    output alu_ready, mem_ready, reg_write_en, reg_write_dest, reg_write_data, busy
  );
`endif
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU/load results are queued in a FIFO and drained one per cycle
// into the GPR write port. Define WB_BYPASS_EN for combinational forwarding lookups.
module wb_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input logic          clk,
  input logic          rst_n,
  wb_arbiter_if.slave  bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef struct packed {
    logic [2:0]  dest;
    logic [15:0] data;
  } entry_t;

  entry_t        fifo [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;
  logic          write_en;
  logic [2:0]    write_dest;
  logic [15:0]   write_data;

  logic   space, grant_alu, grant_mem, alu_acc, mem_acc, push, pop, contested;
  entry_t push_entry;

  // Space comes from the registered count only, so a same-cycle pop never frees a slot.
  always_comb begin
    space      = count < CW'(DEPTH);
    contested  = bus.alu_valid && bus.mem_valid;
    grant_mem  = bus.mem_valid && !(contested && starve_cnt == SW'(STARVE_LIMIT));
    grant_alu  = bus.alu_valid && !grant_mem;
    alu_acc    = bus.alu_valid && bus.alu_ready;
    mem_acc    = bus.mem_valid && bus.mem_ready;
    push       = alu_acc || mem_acc;
    pop        = count != '0;
    push_entry = grant_mem ? entry_t'{bus.mem_dest, bus.mem_data}
                           : entry_t'{bus.alu_dest, bus.alu_data};
  end

  assign bus.alu_ready      = rst_n && space && grant_alu;
  assign bus.mem_ready      = rst_n && space && grant_mem;
  assign bus.reg_write_en   = write_en;
  assign bus.reg_write_dest = write_dest;
  assign bus.reg_write_data = write_data;
  assign bus.busy           = (count != '0) || write_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      write_en   <= 1'b0;
      write_dest <= '0;
      write_data <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= push_entry;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) begin
        write_en   <= 1'b1;
        write_dest <= fifo[rd_ptr].dest;
        write_data <= fifo[rd_ptr].data;
        rd_ptr     <= rd_ptr + 1'b1;
      end else begin
        write_en <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (contested && space && grant_mem)
        starve_cnt <= starve_cnt + 1'b1;
      else if (alu_acc || !bus.alu_valid)
        starve_cnt <= '0;
    end
  end

`ifdef WB_BYPASS_EN
  // Oldest-to-youngest scan so the youngest buffered match overrides the write stage.
  function automatic logic [16:0] lookup(input logic [2:0] addr);
    logic [16:0] res;
    res = '0;
    if (write_en && write_dest == addr) res = {1'b1, write_data};
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count && fifo[rd_ptr + AW'(i)].dest == addr)
        res = {1'b1, fifo[rd_ptr + AW'(i)].data};
    end
    return res;
  endfunction

  always_comb begin
    {bus.byp_hit_1, bus.byp_data_1} = lookup(bus.byp_addr_1);
    {bus.byp_hit_2, bus.byp_data_2} = lookup(bus.byp_addr_2);
  end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_wb_arbiter;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_arbiter_if bus ();

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  d;
    logic [15:0] v;
  } ent_t;

  ent_t        q[$];
  int          starve;
  bit          m_en;
  logic [2:0]  m_dest;
  logic [15:0] m_data;
  int          vectors;
  int          miscompares;
  int          dut_acc;   // 0 none, 1 alu, 2 mem, as observed on the DUT handshake
  bit          alu_taken, mem_taken;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void grants(output bit ga, output bit gm);
    gm = bus.mem_valid && !(bus.alu_valid && starve == STARVE_LIMIT);
    ga = bus.alu_valid && !gm;
  endfunction

  function automatic logic [16:0] byp_model(input logic [2:0] addr);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].d == addr) return {1'b1, q[i].v};
    if (m_en && m_dest == addr) return {1'b1, m_data};
    return '0;
  endfunction

  task automatic model_edge();
    bit ga, gm, sp, acc_a, acc_m;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      starve = 0;
      m_en   = 0;
      m_dest = '0;
      m_data = '0;
      return;
    end
    sp = q.size() < DEPTH;
    grants(ga, gm);
    acc_a = ga && sp;
    acc_m = gm && sp;
    if (q.size() > 0) begin
      e = q.pop_front();
      m_en = 1; m_dest = e.d; m_data = e.v;
    end else begin
      m_en = 0;
    end
    if (acc_a)      q.push_back('{bus.alu_dest, bus.alu_data});
    else if (acc_m) q.push_back('{bus.mem_dest, bus.mem_data});
    if (bus.alu_valid && bus.mem_valid && sp && gm) starve++;
    else if (acc_a || !bus.alu_valid)               starve = 0;
  endtask

  task automatic cycle();
    bit ga, gm, sp;
    @(negedge clk);
    sp = q.size() < DEPTH;
    grants(ga, gm);
    chk("alu_ready", bus.alu_ready, rst_n && sp && ga);
    chk("mem_ready", bus.mem_ready, rst_n && sp && gm);
    chk("busy_mid", bus.busy, (q.size() != 0) || m_en);
`ifdef WB_BYPASS_EN
    chk("byp_1", {bus.byp_hit_1, bus.byp_data_1}, byp_model(bus.byp_addr_1));
    chk("byp_2", {bus.byp_hit_2, bus.byp_data_2}, byp_model(bus.byp_addr_2));
`endif
    alu_taken = bus.alu_valid && bus.alu_ready;
    mem_taken = bus.mem_valid && bus.mem_ready;
    dut_acc   = alu_taken ? 1 : (mem_taken ? 2 : 0);
    @(posedge clk);
    model_edge();
    #1;
    chk("reg_write_en", bus.reg_write_en, m_en);
    chk("reg_write_dest", bus.reg_write_dest, m_dest);
    chk("reg_write_data", bus.reg_write_data, m_data);
    chk("busy", bus.busy, (q.size() != 0) || m_en);
  endtask

  task automatic drive(input bit av, input logic [2:0] ad, input logic [15:0] adata,
                       input bit mv, input logic [2:0] md, input logic [15:0] mdata);
    bus.alu_valid = av; bus.alu_dest = ad; bus.alu_data = adata;
    bus.mem_valid = mv; bus.mem_dest = md; bus.mem_data = mdata;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vectors = 0; miscompares = 0;
    starve = 0; m_en = 0; m_dest = '0; m_data = '0;
    rst_n = 1'b0;
    drive(1, 3'd1, 16'h1111, 0, 3'd0, 16'h0);
`ifdef WB_BYPASS_EN
    bus.byp_addr_1 = 3'd0; bus.byp_addr_2 = 3'd0;
`endif
    @(posedge clk); #1;

    // Reset held two cycles with alu_valid asserted.
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("rst_write_en", bus.reg_write_en, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
    end
    rst_n = 1'b1;
    drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    cycle();

    // Single ALU push.
    drive(1, 3'd3, 16'hA5A5, 0, 3'd0, 16'h0);
    cycle();
    drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    chk("single_busy_E", bus.busy, 1'b1);
    cycle();
    chk("single_en", bus.reg_write_en, 1'b1);
    chk("single_dest", bus.reg_write_dest, 3'd3);
    chk("single_data", bus.reg_write_data, 16'hA5A5);
    cycle();
    chk("single_idle", bus.busy, 1'b0);

    // Contested grants: mem,mem,mem,alu repeating.
    drive(1, 3'd5, 16'h0A00, 1, 3'd6, 16'h0B00);
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("grant_seq", dut_acc, (i % 4 == 3) ? 1 : 2);
      if (alu_taken) begin bus.alu_dest = 3'($urandom); bus.alu_data = 16'($urandom); end
      if (mem_taken) begin bus.mem_dest = 3'($urandom); bus.mem_data = 16'($urandom); end
    end

    // Back-to-back pushes alternating sources; order checked by the model.
    for (int i = 0; i < 6; i++) begin
      drive(i % 2 == 0, 3'(i), 16'(16'h100 + i), i % 2 == 1, 3'(7 - i), 16'(16'h200 + i));
      cycle();
    end
    drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    cycle(); cycle();

    // Mid-operation reset discards buffered work.
    drive(1, 3'd4, 16'hDEAD, 0, 3'd0, 16'h0);
    cycle();
    rst_n = 1'b0;
    drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    cycle();
    chk("midrst_en", bus.reg_write_en, 1'b0);
    rst_n = 1'b1;
    cycle();
    chk("midrst_after", bus.reg_write_en, 1'b0);
    drive(1, 3'd7, 16'h0001, 0, 3'd0, 16'h0);
    cycle();
    drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    cycle();
    chk("repush_en", bus.reg_write_en, 1'b1);
    chk("repush_dest", bus.reg_write_dest, 3'd7);
    chk("repush_data", bus.reg_write_data, 16'h0001);
    cycle();
    chk("repush_single", bus.reg_write_en, 1'b0);

`ifdef WB_BYPASS_EN
    drive(1, 3'd2, 16'd5, 0, 3'd0, 16'h0);
    cycle();
    drive(1, 3'd2, 16'd9, 0, 3'd0, 16'h0);
    cycle();
    drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    bus.byp_addr_1 = 3'd2; bus.byp_addr_2 = 3'd4;
    #1;
    chk("byp_hit_1", bus.byp_hit_1, 1'b1);
    chk("byp_data_1", bus.byp_data_1, 16'd9);
    chk("byp_hit_2", bus.byp_hit_2, 1'b0);
    chk("byp_data_2", bus.byp_data_2, 16'd0);
    cycle(); cycle();
`endif

    // Randomized traffic; a producer holds its payload while stalled.
    drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
`ifdef WB_BYPASS_EN
      bus.byp_addr_1 = 3'($urandom); bus.byp_addr_2 = 3'($urandom);
`endif
      cycle();
      if (!(bus.alu_valid && !alu_taken)) begin
        bus.alu_valid = ($urandom_range(0, 3) != 0);
        bus.alu_dest  = 3'($urandom);
        bus.alu_data  = 16'($urandom);
      end
      if (!(bus.mem_valid && !mem_taken)) begin
        bus.mem_valid = ($urandom_range(0, 2) != 0);
        bus.mem_dest  = 3'($urandom);
        bus.mem_data  = 16'($urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
